regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between two producers: the pipeline
//  writeback stage (WB) and the long-latency mult/div unit (MD).
//  - WB has priority.
//  - MD is guaranteed a grant after MAX_WAIT consecutive losses.
//  - Drives the register file's RegWrite/WriteRegister/WriteData from a registered
//    output stage, so the register file sees clean, glitch-free write controls.
// PARAMETERS
//  MAX_WAIT  4  consecutive cycles MD may lose to WB before MD is forced; legal 1..7
//  CNT_W     3  width of wait counter; must satisfy 2^CNT_W > MAX_WAIT
// PORTS
//  Clk            in   1   clock; all state updates on posedge
//  Rst_n          in   1   synchronous reset, active low
//  wb_valid       in   1   WB has a write pending
//  wb_ready       out  1   WB write accepted this cycle (combinational)
//  wb_reg         in   5   WB destination register
//  wb_data        in   32  WB write data
//  md_valid       in   1   MD has a result pending
//  md_ready       out  1   MD result accepted this cycle (combinational)
//  md_reg         in   5   MD destination register
//  md_data        in   32  MD result data
//  RegWrite       out  1   register-file write enable (registered)
//  WriteRegister  out  5   register-file write address (registered)
//  WriteData      out  32  register-file write data (registered)
//  md_forced      out  1   pulses high for 1 cycle when a grant was made in FORCE state
// BEHAVIOUR
//  Reset (Rst_n==0 at posedge):
//   - RegWrite=0, WriteRegister=0, WriteData=0, md_forced=0
//   - state=NORMAL, wait_cnt=0
//   - wb_ready=md_ready=0 while Rst_n==0
//  Handshake:
//   - A transfer occurs in a cycle where valid&&ready.
//   - The producer holds valid, reg and data stable until ready.
//   - At most one of wb_ready/md_ready is high per cycle.
//   - ready never depends on the other producer's data, only on the valids and state.
//  States:
//   - NORMAL: wb_valid -> grant WB; else md_valid -> grant MD.
//     If both valid and WB is granted: wait_cnt++. When wait_cnt reaches MAX_WAIT,
//     next state = FORCE.
//     MD granted -> wait_cnt=0.
//     md_valid==0 -> wait_cnt=0.
//   - FORCE: md_valid -> grant MD (WB gets ready=0 even if valid), md_forced=1 next
//     cycle, wait_cnt=0, next state NORMAL.
//     md_valid==0 (protocol violation) -> grant per NORMAL rules, next state NORMAL,
//     wait_cnt=0.
//  Output stage, on the posedge ending the grant cycle:
//   - RegWrite<=1, WriteRegister<=granted reg, WriteData<=granted data.
//   - The register file commits one edge later.
//   - Latency from accepted transfer to regfile update: 2 edges.
//   - No grant -> RegWrite<=0. WriteRegister/WriteData hold their last values.
//  Register $0:
//   - A transfer with reg==0 is accepted normally and counts for arbitration.
//   - It produces RegWrite<=0 (no write).
//  Ordering:
//   - Same-cycle WB and MD writes to the same register -> the granted one is written
//     first.
//   - The loser is written in a later cycle, so the loser's value is final.
//   - Hazard avoidance is the pipeline's duty.
//  wait_cnt saturates at MAX_WAIT and never wraps.
//  Reset asserted mid-stream aborts pending grants. No partial write is emitted after
//  reset.
// TESTING
//  1. Reset: hold Rst_n=0 with both valids=1 for 3 cycles -> readies=0, RegWrite=0,
//     WriteRegister=0, WriteData=0.
//  2. WB only: wb_valid=1, wb_reg=5, wb_data=32'hDEADBEEF for 1 cycle -> wb_ready=1
//     same cycle; RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF next cycle;
//     RegWrite=0 the following cycle.
//  3. Starvation: wb_valid=1 every cycle, md_valid=1 (md_reg=3, md_data=7),
//     MAX_WAIT=4 -> WB granted cycles 0-3, MD granted cycle 4, md_forced=1 in cycle 5,
//     WB granted again from cycle 5.
//  4. $0 write: wb_valid=1, wb_reg=0, wb_data=1 -> wb_ready=1, RegWrite stays 0.
//  5. Same target: wb(reg 2, 0xA) and md(reg 2, 0xB) both valid -> WriteData sequence
//     is 0xA then 0xB on WriteRegister=2.
//  6. Reset mid-stream: assert Rst_n=0 in FORCE state -> next cycle state=NORMAL,
//     wait_cnt=0, RegWrite=0; after release WB wins the first contention.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the WB/MD producers and the register-file arbiter.
// The master side is the producer/regfile environment, the slave side is the arbiter.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        md_forced;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output md_valid, md_reg, md_data,
    input  wb_ready, md_ready,
    input  RegWrite, WriteRegister, WriteData,
    input  md_forced
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  md_valid, md_reg, md_data,
    output wb_ready, md_ready,
    output RegWrite, WriteRegister, WriteData,
    output md_forced
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (priority) and MD
// (forced through after MAX_WAIT consecutive losses); registered write outputs.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input logic                   Clk,
  input logic                   Rst_n,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    NORMAL,
    FORCE
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q;
  logic [4:0]        wreg_q;
  logic [31:0]       wdata_q;
  logic              forced_q;

  logic              force_gnt;
  logic              wb_gnt;
  logic              md_gnt;
  logic              any_gnt;
  logic [4:0]        sel_reg;
  logic [31:0]       sel_data;

  // In FORCE without an MD request we fall back to normal priority.
  always_comb begin
    force_gnt = (state_q == FORCE) && bus.md_valid;
    wb_gnt    = Rst_n && bus.wb_valid && !force_gnt;
    md_gnt    = Rst_n && bus.md_valid && !wb_gnt;
    any_gnt   = wb_gnt || md_gnt;
    sel_reg   = wb_gnt ? bus.wb_reg : bus.md_reg;
    sel_data  = wb_gnt ? bus.wb_data : bus.md_data;
  end

  assign bus.wb_ready = wb_gnt;
  assign bus.md_ready = md_gnt;

  always_comb begin
    cnt_d   = '0;
    state_d = NORMAL;
    if (state_q == NORMAL && wb_gnt && bus.md_valid) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == CntMax) begin
        state_d = FORCE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      forced_q <= force_gnt;
      // $0 transfers are consumed but never reach the register file.
      rw_q     <= any_gnt && (sel_reg != 5'd0);
      if (any_gnt) begin
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.RegWrite      = rw_q;
  assign bus.WriteRegister = wreg_q;
  assign bus.WriteData     = wdata_q;
  assign bus.md_forced     = forced_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic checked against a
// loss-counting reference model of the WB/MD arbitration rules.
module tb_regfile_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic Clk;
  logic Rst_n;
  int   errors;
  int   checks;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (3)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0;
    bus.md_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
    bus.md_reg   = '0;
    bus.md_data  = '0;
  endtask

  task automatic test_reset();
    Rst_n        = 1'b0;
    bus.wb_valid = 1'b1;
    bus.md_valid = 1'b1;
    bus.wb_reg   = 5'd9;
    bus.wb_data  = 32'h1234;
    bus.md_reg   = 5'd10;
    bus.md_data  = 32'h5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      checks++;
      if ({bus.wb_ready, bus.md_ready} !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready: got %b want 00",
                 {bus.wb_ready, bus.md_ready});
      end
      tick();
      checks++;
      if ({bus.RegWrite, bus.WriteRegister, bus.WriteData,
           bus.md_forced} !== 39'd0) begin
        errors++;
        $display("FAIL reset_outputs: rw=%b wr=%0d wd=%0h mf=%b want 0",
                 bus.RegWrite, bus.WriteRegister, bus.WriteData,
                 bus.md_forced);
      end
    end
    idle();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wb_only();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    @(negedge Clk);
    checks++;
    if ({bus.wb_ready, bus.md_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wb_only_ready: got %b want 10",
               {bus.wb_ready, bus.md_ready});
    end
    tick();
    idle();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 ||
        bus.WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_only_write: rw=%b wr=%0d wd=%0h want 1 5 deadbeef",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_only_after: rw=%b wd=%0h want 0 deadbeef",
               bus.RegWrite, bus.WriteData);
    end
  endtask

  task automatic test_starvation();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd1;
    bus.wb_data  = 32'h11;
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd3;
    bus.md_data  = 32'd7;
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk);
      checks++;
      if (bus.wb_ready !== (c != 4) || bus.md_ready !== (c == 4)) begin
        errors++;
        $display("FAIL starve_ready c%0d: wb=%b md=%b want wb=%b md=%b",
                 c, bus.wb_ready, bus.md_ready, c != 4, c == 4);
      end
      tick();
      checks++;
      if (bus.md_forced !== (c == 4)) begin
        errors++;
        $display("FAIL starve_forced c%0d: got %b want %b",
                 c, bus.md_forced, c == 4);
      end
      if (c == 4) begin
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd3 ||
            bus.WriteData !== 32'd7) begin
          errors++;
          $display("FAIL starve_md_write: rw=%b wr=%0d wd=%0h want 1 3 7",
                   bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_zero_reg();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd0;
    bus.wb_data  = 32'd1;
    @(negedge Clk);
    checks++;
    if (bus.wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b want 1", bus.wb_ready);
    end
    tick();
    idle();
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL zero_rw: got %b want 0", bus.RegWrite);
    end
    tick();
  endtask

  task automatic test_same_target();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd2;
    bus.wb_data  = 32'hA;
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd2;
    bus.md_data  = 32'hB;
    tick();
    bus.wb_valid = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd2 ||
        bus.WriteData !== 32'hA) begin
      errors++;
      $display("FAIL same_first: rw=%b wr=%0d wd=%0h want 1 2 a",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    tick();
    idle();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd2 ||
        bus.WriteData !== 32'hB) begin
      errors++;
      $display("FAIL same_second: rw=%b wr=%0d wd=%0h want 1 2 b",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd4;
    bus.wb_data  = 32'h44;
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd6;
    bus.md_data  = 32'h66;
    repeat (MAX_WAIT) tick();
    Rst_n = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.wb_ready, bus.md_ready} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 00",
               {bus.wb_ready, bus.md_ready});
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.md_forced !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out: rw=%b mf=%b want 0 0",
               bus.RegWrite, bus.md_forced);
    end
    Rst_n = 1'b1;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      @(negedge Clk);
      checks++;
      if (bus.wb_ready !== (c != MAX_WAIT) ||
          bus.md_ready !== (c == MAX_WAIT)) begin
        errors++;
        $display("FAIL midrst_arb c%0d: wb=%b md=%b want wb=%b md=%b",
                 c, bus.wb_ready, bus.md_ready,
                 c != MAX_WAIT, c == MAX_WAIT);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int          losses;
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_forced;
    logic        rst;
    logic        frc;
    logic        wb_g;
    logic        md_g;
    logic [4:0]  g_reg;
    logic [31:0] g_data;

    losses   = 0;
    m_rw     = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
    m_forced = 1'b0;
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst = (i != 0) && ($urandom_range(0, 59) != 0);
      Rst_n = rst;
      if (!bus.wb_valid && $urandom_range(0, 1) == 1) begin
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'($urandom_range(0, 7));
        bus.wb_data  = $urandom;
      end
      if (!bus.md_valid && $urandom_range(0, 2) != 0) begin
        bus.md_valid = 1'b1;
        bus.md_reg   = 5'($urandom_range(0, 7));
        bus.md_data  = $urandom;
      end

      frc  = (losses >= MAX_WAIT) && bus.md_valid;
      wb_g = rst && bus.wb_valid && !frc;
      md_g = rst && bus.md_valid && !wb_g;

      @(negedge Clk);
      checks++;
      if (bus.wb_ready !== wb_g || bus.md_ready !== md_g) begin
        errors++;
        $display("FAIL rand_ready i%0d: wb=%b md=%b want wb=%b md=%b",
                 i, bus.wb_ready, bus.md_ready, wb_g, md_g);
      end
      tick();

      if (!rst) begin
        losses   = 0;
        m_rw     = 1'b0;
        m_wreg   = '0;
        m_wdata  = '0;
        m_forced = 1'b0;
      end else begin
        m_forced = frc;
        if (losses >= MAX_WAIT) losses = 0;
        else if (wb_g && bus.md_valid) losses = losses + 1;
        else losses = 0;
        g_reg  = wb_g ? bus.wb_reg : bus.md_reg;
        g_data = wb_g ? bus.wb_data : bus.md_data;
        m_rw   = (wb_g || md_g) && (g_reg != 5'd0);
        if (wb_g || md_g) begin
          m_wreg  = g_reg;
          m_wdata = g_data;
        end
      end

      checks++;
      if (bus.RegWrite !== m_rw || bus.WriteRegister !== m_wreg ||
          bus.WriteData !== m_wdata || bus.md_forced !== m_forced) begin
        errors++;
        $display("FAIL rand_out i%0d: rw=%b wr=%0d wd=%0h mf=%b want %b %0d %0h %b",
                 i, bus.RegWrite, bus.WriteRegister, bus.WriteData,
                 bus.md_forced, m_rw, m_wreg, m_wdata, m_forced);
      end
      if (wb_g) bus.wb_valid = 1'b0;
      if (md_g) bus.md_valid = 1'b0;
    end
    idle();
    Rst_n = 1'b1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Rst_n  = 1'b0;
    idle();
    #1;
    test_reset();
    test_wb_only();
    test_starvation();
    test_zero_reg();
    test_same_target();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
